// File: rtl/data_mem_responder_pkg.sv
// Shared state encoding, parameter defaults and address-fault helper for the
// wait-state data memory responder.
package data_mem_responder_pkg;

  localparam int unsigned DEPTH_DEFAULT       = 64;
  localparam int unsigned WAIT_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  // Misaligned or beyond the last word
  function automatic logic isFault(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= depth);
  endfunction

endpackage

// File: rtl/be_merge.sv
// Byte-lane merge: lanes with be[i] set take wdata, the rest keep the old word.
// be[3] selects bits 31:24 (byte offset 0, big-endian).
module be_merge (
  input  logic [31:0] oldWord,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] newWord
);

  always_comb begin
    newWord = oldWord;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) newWord[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering CPU requests after WAIT_CYCLES wait states
// with a one-cycle ack; faults on misaligned or out-of-range addresses.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = DEPTH_DEFAULT,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  stateT       state;
  logic [3:0]  count;
  logic        capWe;
  logic [31:0] capAddr;
  logic [31:0] capWdata;
  logic [3:0]  capBe;
  logic [31:0] mem [DEPTH];

  logic             accWe;
  logic [31:0]      accAddr;
  logic [31:0]      accWdata;
  logic [3:0]       accBe;
  logic             accFault;
  logic [IDX_W-1:0] accIdx;
  logic [31:0]      mergedWord;
  logic             doAccess;

  // With zero wait states the access happens on the capture edge, so the
  // live inputs feed the access path instead of the capture registers.
  always_comb begin
    accWe    = (state == IDLE) ? we    : capWe;
    accAddr  = (state == IDLE) ? addr  : capAddr;
    accWdata = (state == IDLE) ? wdata : capWdata;
    accBe    = (state == IDLE) ? be    : capBe;
    accFault = isFault(accAddr, DEPTH);
    accIdx   = accAddr[IDX_W+1:2];
    doAccess = 1'b0;
    case (state)
      IDLE:    doAccess = req && (WAIT_CYCLES == 0);
      WAIT:    doAccess = (count == 4'd1);
      default: doAccess = 1'b0;
    endcase
  end

  be_merge uMerge (
    .oldWord (mem[accIdx]),
    .wdata   (accWdata),
    .be      (accBe),
    .newWord (mergedWord)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      count    <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      capWe    <= 1'b0;
      capAddr  <= '0;
      capWdata <= '0;
      capBe    <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            capWe    <= we;
            capAddr  <= addr;
            capWdata <= wdata;
            capBe    <= be;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              count <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (doAccess) begin
        ack <= 1'b1;
        err <= accFault;
        if (accFault)    rdata <= '0;
        else if (!accWe) rdata <= mem[accIdx];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (doAccess && accWe && !accFault) begin
      mem[accIdx] <= mergedWord;
    end
  end

endmodule
